// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

  // Widest operand the datapath is meant to be built with.
  localparam int MAX_WIDTH = 32;

  // Controller states: waiting for a request, one bit per clock, result pulse.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor: D = A - B - B_IN with borrow-out.
// This is the single arithmetic cell that the serial datapath reuses on every bit.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic B_IN,
  output logic D,
  output logic B_OUT
);

  assign D     = A ^ B ^ B_IN;
  // A borrow is generated when A=0, B=1, and propagated when A==B.
  assign B_OUT = (~A & B) | (~(A ^ B) & B_IN);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = A - B - B_IN, LSB first.
// A START accepted in IDLE captures the operands; WIDTH SHIFT cycles follow,
// then a single FINISH cycle pulses DONE with D/B_OUT already valid.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds a signed-overflow output V.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_IN,
  output logic [WIDTH-1:0] D,
  output logic             B_OUT,
  output logic             BUSY,
  output logic             DONE
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       state;
  sub_state_t       state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_bout;
  logic             load;
  logic             last;

  // The one subtract cell, fed by the low bits of the operand shifters.
  full_subtractor u_cell (
    .A     (a_sr[0]),
    .B     (b_sr[0]),
    .B_IN  (borrow),
    .D     (bit_d),
    .B_OUT (bit_bout)
  );

  assign last = (state == SHIFT) && (cnt == LAST_BIT);

  // State register; reset is synchronous so it only acts on a clock edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and Moore outputs (BUSY/DONE depend on state only).
  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        BUSY = 1'b1;
        if (cnt == LAST_BIT) state_nxt = FINISH;
      end
      FINISH: begin
        BUSY      = 1'b1;
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per SHIFT cycle, publish on the last.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      B_OUT  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      V      <= 1'b0;
`endif
    end else if (load) begin
      a_sr   <= A;
      b_sr   <= B;
      borrow <= B_IN;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      r_sr   <= {bit_d, r_sr[WIDTH-1:1]};
      borrow <= bit_bout;
      cnt    <= cnt + 1'b1;
      if (last) begin
        D     <= {bit_d, r_sr[WIDTH-1:1]};
        B_OUT <= bit_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
        // On the last bit a_sr[0]/b_sr[0] are the sign bits: overflow only
        // when the signs differ and the result sign departs from A.
        V     <= (a_sr[0] ^ b_sr[0]) & (bit_d ^ a_sr[0]);
`endif
      end
    end
  end

endmodule
